// File: rtl/rand_range_fifo.sv
// rand_range_fifo: consumer of a 32-bit random word generator.
// Each 0->1 edge of rand_ready captures rand_result. The word is scaled into [lo, lo+span)
// by taking the high half of rand_result*span, or passed through raw when span is 0. Results
// are buffered in a FIFO with a valid/ready output. gen_en throttles the generator so that
// every sample has a slot waiting for it.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   flush             synchronous clear of FIFO, in-flight sample and overflow flag
//   span, lo          range width (0 = raw passthrough) and range base, sampled on capture
//   gen_en            registered enable to the generator
//   rand_ready        generator ready level; its rising edge marks a new word
//   rand_result       generator word
//   out_valid/ready   FIFO head handshake; out_data is the head value (0 while empty)
//   level             FIFO occupancy 0..DEPTH
//   overflow          sticky: a sample was dropped because the FIFO was full with no pop
//   sample_cnt        samples written into the FIFO, wraps
module rand_range_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic [31:0]   span,
  input  logic [31:0]   lo,
  output logic          gen_en,
  input  logic          rand_ready,
  input  logic [31:0]   rand_result,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_data,
  output logic [AW:0]   level,
  output logic          overflow,
  output logic [31:0]   sample_cnt
);

  localparam logic [AW:0] DepthW = (AW + 1)'(DEPTH);

  logic [31:0] mem [DEPTH];

  logic        rdy_q;
  logic        new_smp;
  logic        s1_valid_q, s1_valid_d;
  logic        s1_zero_q;
  logic [63:0] s1_prod_q;
  logic [31:0] s1_raw_q;
  logic [31:0] s1_lo_q;

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0] level_d;
  logic [AW:0] free_d;
  logic        gen_en_q, gen_en_d;
  logic        overflow_q, overflow_d;
  logic [31:0] sample_cnt_q, sample_cnt_d;

  logic        wr_req;
  logic        pop;
  logic        full;
  logic        accept;
  logic        drop;
  logic [31:0] s2_value;

  assign new_smp = rand_ready & ~rdy_q;

  assign level     = wr_ptr_q - rd_ptr_q;
  assign out_valid = (level != '0);
  assign full      = (level == DepthW);
  assign out_data  = out_valid ? mem[rd_ptr_q[AW-1:0]] : '0;

  assign gen_en     = gen_en_q;
  assign overflow   = overflow_q;
  assign sample_cnt = sample_cnt_q;

  // Stage 2: finish the scaling from the registered product.
  assign s2_value = s1_zero_q ? s1_raw_q : s1_lo_q + s1_prod_q[63:32];

  always_comb begin
    wr_req = s1_valid_q & ~flush;
    pop    = out_valid & out_ready & ~flush;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    accept = wr_req & (~full | pop);
    drop   = wr_req & full & ~pop;

    s1_valid_d   = new_smp & ~flush;
    wr_ptr_d     = flush ? '0 : wr_ptr_q + (AW + 1)'(accept);
    rd_ptr_d     = flush ? '0 : rd_ptr_q + (AW + 1)'(pop);
    overflow_d   = ~flush & (overflow_q | drop);
    sample_cnt_d = sample_cnt_q + 32'(accept);

    level_d  = wr_ptr_d - rd_ptr_d;
    free_d   = DepthW - level_d;
    // Keep two free slots beyond the in-flight sample: gen_en is registered and the generator
    // may already be raising rand_ready when it drops.
    gen_en_d = (free_d >= ((AW + 1)'(2) + (AW + 1)'(s1_valid_d)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_q        <= 1'b0;
      s1_valid_q   <= 1'b0;
      s1_zero_q    <= 1'b0;
      s1_prod_q    <= '0;
      s1_raw_q     <= '0;
      s1_lo_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      gen_en_q     <= 1'b0;
      overflow_q   <= 1'b0;
      sample_cnt_q <= '0;
    end else begin
      rdy_q      <= rand_ready;
      s1_valid_q <= s1_valid_d;
      // Stage 1: span and lo are sampled only with the word they scale.
      if (new_smp) begin
        s1_prod_q <= 64'(rand_result) * 64'(span);
        s1_raw_q  <= rand_result;
        s1_lo_q   <= lo;
        s1_zero_q <= (span == '0);
      end
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      gen_en_q     <= gen_en_d;
      overflow_q   <= overflow_d;
      sample_cnt_q <= sample_cnt_d;
    end
  end

  // Storage needs no reset: out_data is gated while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_ptr_q[AW-1:0]] <= s2_value;
    end
  end

endmodule

// File: tb/tb_rand_range_fifo.sv
module tb_rand_range_fifo;

  localparam int unsigned Depth = 16;
  localparam int unsigned Aw    = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic [31:0]   span;
  logic [31:0]   lo;
  logic          gen_en;
  logic          rand_ready;
  logic [31:0]   rand_result;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_data;
  logic [Aw:0]   level;
  logic          overflow;
  logic [31:0]   sample_cnt;

  int unsigned errs   = 0;
  int unsigned checks = 0;
  logic [31:0] sb [$];
  logic [31:0] exp_cnt;

  rand_range_fifo #(
    .DEPTH (Depth),
    .AW    (Aw)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .span        (span),
    .lo          (lo),
    .gen_en      (gen_en),
    .rand_ready  (rand_ready),
    .rand_result (rand_result),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .level       (level),
    .overflow    (overflow),
    .sample_cnt  (sample_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [31:0] w, input logic [31:0] sp,
                                        input logic [31:0] base);
    logic [63:0] p;
    p = 64'(w) * 64'(sp);
    return (sp == 0) ? w : base + p[63:32];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] v);
    sb.push_back(v);
    exp_cnt = exp_cnt + 1;
  endtask

  // One rising edge on rand_ready; returns after the FIFO write edge.
  task automatic pulse(input logic [31:0] w, input bit accepted);
    rand_result = w;
    rand_ready  = 1'b1;
    if (accepted) push_exp(model(w, span, lo));
    step();
    rand_ready = 1'b0;
    step();
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 20 && out_valid; i++) step();
    out_ready = 1'b0;
    check("drain_level", level, 0);
    check("drain_sb", sb.size(), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gen_en"}, gen_en, 0);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_data"}, out_data, 0);
    check({tag, "_level"}, level, 0);
    check({tag, "_ovf"}, overflow, 0);
    check({tag, "_cnt"}, sample_cnt, 0);
  endtask

  // Scoreboard side: a pop happens at the next rising edge when valid & ready.
  always @(negedge clk) begin
    if (rst_n && !flush && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("pop_unexpected", 32'(sb.size()), 1);
      end else begin
        check("pop_data", out_data, sb.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", errs);
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] words [3];
    logic [31:0] dice  [3];
    logic [31:0] w;
    words[0] = 32'h8000_0000; words[1] = 32'hFFFF_FFFF; words[2] = 32'h0000_0000;
    dice[0]  = 32'd4;         dice[1]  = 32'd6;         dice[2]  = 32'd1;

    rst_n = 1'b0; flush = 1'b0; span = '0; lo = '0; rand_ready = 1'b0;
    rand_result = '0; out_ready = 1'b0; exp_cnt = '0;
    #2;
    check_all_zero("reset");
    step(); step();
    rst_n = 1'b1;
    check("gen_en_pre", gen_en, 0);
    step();
    check("gen_en_post_reset", gen_en, 1);

    // Dice: each result appears two edges after rand_ready rises.
    span = 32'd6; lo = 32'd1;
    for (int i = 0; i < 3; i++) begin
      rand_result = words[i];
      rand_ready  = 1'b1;
      push_exp(dice[i]);
      check("dice_nobypass", out_valid, 0);
      step();
      check("dice_valid_e1", out_valid, 0);
      rand_ready = 1'b0;
      step();
      check("dice_valid_e2", out_valid, 1);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("dice_popped", out_valid, 0);
    end
    check("dice_cnt", sample_cnt, 3);
    check("dice_sb", sb.size(), 0);

    // Raw passthrough ignores lo.
    span = 32'd0; lo = 32'd5;
    rand_result = 32'hDEAD_BEEF;
    rand_ready  = 1'b1;
    push_exp(32'hDEAD_BEEF);
    step();
    rand_ready = 1'b0;
    step();
    drain();

    // A level held high yields one sample.
    span = 32'd100; lo = 32'd1000;
    rand_result = 32'h4000_0000;
    rand_ready  = 1'b1;
    push_exp(32'd1025);
    for (int i = 0; i < 10; i++) step();
    rand_ready = 1'b0;
    step(); step();
    check("held_level", level, 1);
    check("held_cnt", sample_cnt, exp_cnt);
    drain();

    // Backpressure with the generator obeying gen_en.
    span = 32'd1000; lo = 32'd7;
    for (int i = 0; i < 80; i++) begin
      if (gen_en && !rand_ready) begin
        w = $urandom;
        rand_result = w;
        rand_ready  = 1'b1;
        push_exp(model(w, span, lo));
      end else begin
        rand_ready = 1'b0;
      end
      step();
    end
    rand_ready = 1'b0;
    step(); step(); step();
    check("bp_level_sb", level, sb.size());
    check("bp_level_ge15", level >= 15, 1);
    check("bp_gen_en", gen_en, 0);
    check("bp_ovf", overflow, 0);
    check("bp_cnt", sample_cnt, exp_cnt);

    // Top up to full ignoring gen_en.
    while (sb.size() < Depth) pulse($urandom, 1'b1);
    check("full_level", level, Depth);
    check("full_ovf", overflow, 0);

    // Full, pop and write in the same cycle.
    w = $urandom;
    rand_result = w;
    rand_ready  = 1'b1;
    push_exp(model(w, span, lo));
    step();
    rand_ready = 1'b0;
    out_ready  = 1'b1;
    step();
    out_ready = 1'b0;
    check("fpw_level", level, Depth);
    check("fpw_ovf", overflow, 0);
    check("fpw_cnt", sample_cnt, exp_cnt);

    // Full, write, no pop: dropped.
    pulse($urandom, 1'b0);
    check("drop_level", level, Depth);
    check("drop_ovf", overflow, 1);
    check("drop_cnt", sample_cnt, exp_cnt);

    // Flush clears FIFO and overflow, keeps the count.
    flush = 1'b1;
    step();
    flush = 1'b0;
    sb.delete();
    check("flush_level", level, 0);
    check("flush_valid", out_valid, 0);
    check("flush_ovf", overflow, 0);
    check("flush_cnt", sample_cnt, exp_cnt);
    check("flush_gen_en", gen_en, 1);

    // Reset in the middle of a burst.
    span = 32'd6; lo = 32'd1;
    for (int i = 0; i < 3; i++) pulse(words[i], 1'b1);
    rand_result = 32'h1234_5678;
    rand_ready  = 1'b1;
    #3;
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    sb.delete();
    exp_cnt    = '0;
    rand_ready = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    check("midreset_gen_en", gen_en, 1);
    check("midreset_level", level, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
